alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the single-cycle integer ALU.
//  Adds shifts, signed/unsigned compare, and iterative MUL/DIVU/REMU.
//  Sits between decode/issue and writeback.
//  Uses valid/ready on input and output, so long-latency ops can stall
//  issue without the pipeline tracking cycle counts.
// PARAMETERS
//  WIDTH          32  operand/result width in bits; >=2, power of 2
//  ENABLE_MULDIV  1   1: MUL/DIVU/REMU iterative; 0: these ops set err
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operands and op presented
//  in_ready   out  1        block can accept; transfer = in_valid&in_ready
//  src_a      in   WIDTH    operand A
//  src_b      in   WIDTH    operand B
//  alu_op     in   alu_op_e operation select (4-bit enum, shared package)
//  out_valid  out  1        result/err valid
//  out_ready  in   1        consumer accepts; transfer = out_valid&out_ready
//  result     out  WIDTH    registered result
//  err        out  1        op illegal or disabled; result forced to 0
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0,
//   result=0, err=0, iteration counter=0.
//  FSM states: IDLE, BUSY, DONE.
//   IDLE->DONE: accept of 1-cycle op (ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,
//    SLTU, illegal, or muldiv with ENABLE_MULDIV=0).
//   IDLE->BUSY: accept of MUL/DIVU/REMU (ENABLE_MULDIV=1).
//   BUSY->DONE: after exactly WIDTH iterations.
//   DONE->IDLE: out_ready=1 and no new accept.
//   DONE->DONE/BUSY: out_ready=1 with simultaneous accept.
//  in_ready = (state==IDLE) | (state==DONE & out_ready), combinational.
//   Back-to-back 1-cycle ops sustain 1 op/cycle.
//  out_valid = (state==DONE). result/err held stable while out_valid&!out_ready.
//  Latency: 1-cycle op accepted at edge N -> out_valid from cycle N+1.
//   Iterative op -> out_valid from cycle N+WIDTH+1.
//  Arithmetic: ADD/SUB wrap mod 2^WIDTH; no carry/overflow output.
//   Shifts use src_b[$clog2(WIDTH)-1:0]; upper bits ignored. SRA sign-fills.
//   SLT signed, SLTU unsigned; result = {WIDTH-1 zeros, flag}.
//   MUL returns low WIDTH bits of the product (sign-agnostic).
//   DIVU/REMU are unsigned restoring division.
//   Divide by zero: DIVU = all ones, REMU = src_a, err=0.
//  Operands are latched at accept; src_a/src_b may change during BUSY.
//  Unknown alu_op encoding: result=0, err=1, 1-cycle path.
//  Reset mid-BUSY aborts the op; no output is produced for it.
// STRUCTURE
//  Shared package types.sv: alu_op_e extended to 4 bits.
//   Existing ADD..XOR encodings are kept unchanged.
//   New members: ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL,
//   ALU_DIVU, ALU_REMU. Add helper function is_iterative(alu_op_e).
//  Sub-module alu_muldiv_iter #(WIDTH): start/busy/done interface.
//   Shift-add multiplier and restoring divider share one 2*WIDTH-bit
//   accumulator and a $clog2(WIDTH)+1 counter.
//   Generated only when ENABLE_MULDIV=1.
//  Top level holds the FSM, 1-cycle datapath and output register.
// TESTING  (WIDTH=32 unless noted)
//  ADD 0xFFFFFFFF+1, out_ready=1 -> result 0x0 at N+1, err=0.
//   Then SUB 0-1 next cycle -> 0xFFFFFFFF at N+2 (throughput 1/cycle).
//  SRA 0x80000000 by 0x24 (shamt 4) -> 0xF8000000.
//   SLT 0xFFFFFFFF vs 1 -> 1. SLTU same operands -> 0.
//  MUL 0x0001_0003 * 0x0000_0005 -> 0x0005_000F at N+33.
//   in_ready=0 during cycles N+1..N+32.
//  DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
//  Backpressure: hold out_ready=0 for 10 cycles after ADD 2+3.
//   Result stays 5 and out_valid stays 1. New in_valid is not accepted
//   until the cycle out_ready rises.
//  rst_n low at BUSY cycle 10 of a DIVU -> out_valid=0, in_ready=1
//   immediately. ENABLE_MULDIV=0 with MUL op -> err=1, result=0 at N+1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared ALU operation encodings, FSM state type and op-class helper.
// Pure type/function package: no latency. No backpressure.
// Unknown 4-bit encodings (13..15) are treated as illegal by consumers.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIVU = 4'd11,
        ALU_REMU = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_iterative(input alu_op_e op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on one 2*WIDTH accumulator.
// Latency: WIDTH cycles after start; done_o flags the final iteration edge.
// No backpressure: caller must capture res_o in the cycle done_o is high.
module alu_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q, div_q, rem_q;
    logic [WIDTH:0]     msum, rshift, rdiff;

    // Multiply: {hi,lo} with multiplier in lo, shift right each step.
    // Divide: {rem,quo} with dividend in quo, shift left and trial-subtract.
    always_comb begin
        msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rshift = acc_q[2*WIDTH-1:WIDTH-1];
        rdiff  = rshift - {1'b0, b_q};
        acc_d  = {msum, acc_q[WIDTH-1:1]};
        if (div_q) begin
            if (rdiff[WIDTH]) begin
                acc_d = {rshift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {rdiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign res_o  = rem_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            rem_q  <= 1'b0;
        end else if (start_i) begin
            acc_q  <= {{WIDTH{1'b0}}, a_i};
            b_q    <= b_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            div_q  <= (op_i != ALU_MUL);
            rem_q  <= (op_i == ALU_REMU);
        end else if (busy_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked integer ALU: 1-cycle ops plus optional iterative MUL/DIVU/REMU.
// Latency: 1 cycle for simple ops, WIDTH+1 cycles for iterative ops.
// Backpressure: in_ready drops while busy or while a result is held unconsumed.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  alu_op_e          alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state_q;
    logic [WIDTH-1:0] result_q;
    logic             err_q;
    logic             accept, go_busy;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] md_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic [SHW-1:0]   shamt;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign err       = err_q;
    assign accept    = in_valid && in_ready;
    assign go_busy   = ENABLE_MULDIV && is_iterative(alu_op);
    assign shamt     = src_b[SHW-1:0];

    // Disabled mul/div encodings land in default alongside unknown codes.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (alu_op)
            ALU_ADD:  alu_res = src_a + src_b;
            ALU_SUB:  alu_res = src_a - src_b;
            ALU_AND:  alu_res = src_a & src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_SLL:  alu_res = src_a << shamt;
            ALU_SRL:  alu_res = src_a >> shamt;
            ALU_SRA:  alu_res = $signed(src_a) >>> shamt;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
            default:  alu_err = 1'b1;
        endcase
    end

    if (ENABLE_MULDIV) begin : g_md
        alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
            .clk     (clk),
            .rst_n   (rst_n),
            .start_i (accept && go_busy),
            .op_i    (alu_op),
            .a_i     (src_a),
            .b_i     (src_b),
            .busy_o  (md_busy),
            .done_o  (md_done),
            .res_o   (md_res)
        );
    end else begin : g_no_md
        assign md_busy = 1'b0;
        assign md_done = 1'b0;
        assign md_res  = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            state_q <= go_busy ? ST_BUSY : ST_DONE;
            if (!go_busy) begin
                result_q <= alu_res;
                err_q    <= alu_err;
            end
        end else if ((state_q == ST_BUSY) && md_busy && md_done) begin
            state_q  <= ST_DONE;
            result_q <= md_res;
            err_q    <= 1'b0;
        end else if ((state_q == ST_DONE) && out_ready) begin
            state_q <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases plus randomized ops vs a reference model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, err;
    logic [31:0] src_a = '0, src_b = '0, result;
    alu_op_e     alu_op = ALU_ADD;

    logic        in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1, err0;
    logic [31:0] src_a0 = '0, src_b0 = '0, result0;
    alu_op_e     alu_op0 = ALU_ADD;

    int   tests = 0, fails = 0;
    exp_t exp_q[$];
    logic rand_rdy = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src_a(src_a), .src_b(src_b), .alu_op(alu_op), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .err(err)
    );

    alu_seq #(.WIDTH(32), .ENABLE_MULDIV(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .src_a(src_a0), .src_b(src_b0), .alu_op(alu_op0), .out_valid(out_valid0),
        .out_ready(out_ready0), .result(result0), .err(err0)
    );

    function automatic exp_t model(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        e.err = 1'b0;
        e.res = '0;
        case (op)
            ALU_ADD:  e.res = a + b;
            ALU_SUB:  e.res = a - b;
            ALU_AND:  e.res = a & b;
            ALU_OR:   e.res = a | b;
            ALU_XOR:  e.res = a ^ b;
            ALU_SLL:  e.res = a << b[4:0];
            ALU_SRL:  e.res = a >> b[4:0];
            ALU_SRA:  e.res = $signed(a) >>> b[4:0];
            ALU_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
            ALU_MUL:  begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; end
            ALU_DIVU: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: e.res = (b == 0) ? a : a % b;
            default:  e.err = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Drives one request from posedge+1, pushes the expectation at the accepting negedge.
    task automatic issue_exp(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                             input exp_t e, output int waited, output logic ov1);
        logic got;
        got = 1'b0; waited = 0; ov1 = 1'b0;
        alu_op = op; src_a = a; src_b = b; in_valid = 1'b1;
        while (!got && waited <= 200) begin
            @(negedge clk);
            if (waited == 0) ov1 = out_valid;
            if (in_ready) begin
                exp_q.push_back(e);
                got = 1'b1;
            end else begin
                waited++;
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL issue_timeout: in_ready got 0 expected 1 within 200 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        src_a = $urandom; src_b = $urandom;
        alu_op = alu_op_e'(4'($urandom_range(0, 15)));
    endtask

    task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        int   w;
        logic o;
        issue_exp(op, a, b, model(op, a, b), w, o);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL spurious_output: got res=%h err=%0b expected no output", result, err);
            end else begin
                e = exp_q.pop_front();
                if ({err, result} !== {e.err, e.res}) begin
                    fails++;
                    $display("FAIL result: got err=%0b res=%h expected err=%0b res=%h",
                             err, result, e.err, e.res);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int   w, bad;
        logic ov;
        exp_t e;

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_result",    result,         32'd0);
        chk("rst_err",       32'(err),       32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Wrap-around add then sub accepted in the very next cycle.
        issue_exp(ALU_ADD, 32'hFFFF_FFFF, 32'd1, '{err: 1'b0, res: 32'h0}, w, ov);
        issue_exp(ALU_SUB, 32'd0, 32'd1, '{err: 1'b0, res: 32'hFFFF_FFFF}, w, ov);
        chk("add_valid_n1", 32'(ov), 32'd1);
        chk("sub_no_wait", 32'(w), 32'd0);
        @(negedge clk);
        chk("sub_valid_n2", {31'd0, out_valid}, 32'd1);
        chk("sub_result_n2", result, 32'hFFFF_FFFF);
        @(posedge clk); #1;

        issue_exp(ALU_SRA,  32'h8000_0000, 32'h24, '{err: 1'b0, res: 32'hF800_0000}, w, ov);
        issue_exp(ALU_SLT,  32'hFFFF_FFFF, 32'd1,  '{err: 1'b0, res: 32'd1}, w, ov);
        issue_exp(ALU_SLTU, 32'hFFFF_FFFF, 32'd1,  '{err: 1'b0, res: 32'd0}, w, ov);
        issue_exp(alu_op_e'(4'd13), 32'd7, 32'd9, '{err: 1'b1, res: 32'd0}, w, ov);

        // MUL latency: in_ready low for WIDTH cycles, result visible at N+33.
        issue_exp(ALU_MUL, 32'h0001_0003, 32'h5, '{err: 1'b0, res: 32'h0005_000F}, w, ov);
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (in_ready || out_valid) bad++;
        end
        chk("mul_stall_cycles", 32'(bad), 32'd0);
        @(negedge clk);
        chk("mul_valid_n33", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        issue_exp(ALU_DIVU, 32'd100, 32'd7, '{err: 1'b0, res: 32'd14}, w, ov);
        issue_exp(ALU_REMU, 32'd100, 32'd7, '{err: 1'b0, res: 32'd2}, w, ov);
        issue_exp(ALU_DIVU, 32'd5, 32'd0, '{err: 1'b0, res: 32'hFFFF_FFFF}, w, ov);
        issue_exp(ALU_REMU, 32'd5, 32'd0, '{err: 1'b0, res: 32'd5}, w, ov);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;

        // Backpressure: result held, no accept until out_ready rises.
        issue_exp(ALU_ADD, 32'd2, 32'd3, '{err: 1'b0, res: 32'd5}, w, ov);
        out_ready = 1'b0;
        in_valid = 1'b1; alu_op = ALU_SUB; src_a = 32'd9; src_b = 32'd4;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!out_valid || result !== 32'd5 || in_ready) bad++;
        end
        chk("bp_hold", 32'(bad), 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        issue_exp(ALU_SUB, 32'd9, 32'd4, '{err: 1'b0, res: 32'd5}, w, ov);
        chk("bp_accept_on_rise", 32'(w), 32'd0);
        @(posedge clk); #1;

        // Reset during BUSY of a DIVU aborts it.
        issue_exp(ALU_DIVU, 32'd1000, 32'd3, '{err: 1'b0, res: 32'd333}, w, ov);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        if (exp_q.size() != 0) e = exp_q.pop_back();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_output", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Muldiv disabled: MUL is a 1-cycle error.
        alu_op0 = ALU_MUL; src_a0 = 32'd3; src_b0 = 32'd5; in_valid0 = 1'b1;
        @(negedge clk);
        chk("nomd_in_ready", 32'(in_ready0), 32'd1);
        @(posedge clk); #1 in_valid0 = 1'b0;
        @(negedge clk);
        chk("nomd_mul_valid",  32'(out_valid0), 32'd1);
        chk("nomd_mul_err",    32'(err0),       32'd1);
        chk("nomd_mul_result", result0,         32'd0);
        @(posedge clk); #1;
        alu_op0 = ALU_ADD; src_a0 = 32'd3; src_b0 = 32'd4; in_valid0 = 1'b1;
        @(posedge clk); #1 in_valid0 = 1'b0;
        @(negedge clk);
        chk("nomd_add_result", result0, 32'd7);
        chk("nomd_add_err", 32'(err0), 32'd0);
        @(posedge clk); #1;

        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            issue(alu_op_e'(4'($urandom_range(0, 15))), rnd_val(), rnd_val());
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("drain_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
